// File: rtl/bit_stuff_pkg.sv
// Shared types for the configurable USB bit stuffer/unstuffer.
package bit_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        INSERT = 2'd2
    } stuff_state_t;

    typedef enum logic {
        STUFF_TX   = 1'b0,
        UNSTUFF_RX = 1'b1
    } stuff_mode_t;

endpackage

// File: rtl/bit_stuff_p_run_counter.sv
// Saturating counter of consecutive STUFF_VAL bits; at_limit flags a full run.
module run_counter
    import bit_stuff_pkg::*;
#(
    parameter int   RUN_LEN   = 6,
    parameter logic STUFF_VAL = 1'b1,
    localparam int  CNT_W     = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic             in_bit,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_en) begin
            if (in_bit != STUFF_VAL) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(RUN_LEN)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == CNT_W'(RUN_LEN));

endmodule

// File: rtl/bit_stuff_p.sv
// Bit stuffer (TX) / unstuffer (RX): inserts or removes ~STUFF_VAL after
// every RUN_LEN consecutive STUFF_VAL bits, flagging RX stuff violations.
module bit_stuff_p
    import bit_stuff_pkg::*;
#(
    parameter int   RUN_LEN   = 6,
    parameter logic STUFF_VAL = 1'b1,
    localparam int  CNT_W     = $clog2(RUN_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic start,
    input  logic s_in,
    input  logic in_valid,
    input  logic endb,
    output logic pause,
    output logic s_out,
    output logic out_valid,
    output logic start_nrzi,
    output logic done,
    output logic stuff_err,
    output logic busy
);

    // Handshake: an input bit is consumed on a rising edge where state is
    // ACTIVE and in_valid is high; pause (INSERT only) tells upstream to hold
    // its bit. Outputs are registered and valid only in the cycle out_valid=1.
    stuff_state_t     state_q, state_d;
    stuff_mode_t      mode_q, mode_d;
    logic             endb_pend_q, endb_pend_d;
    logic             first_q, first_d;
    logic             s_out_q, s_out_d;
    logic             out_valid_q, out_valid_d;
    logic             start_nrzi_q, start_nrzi_d;
    logic             done_q, done_d;
    logic             stuff_err_q, stuff_err_d;
    logic             cnt_clr, cnt_inc, at_limit, run_hit;
    logic [CNT_W-1:0] cnt;

    run_counter #(
        .RUN_LEN   (RUN_LEN),
        .STUFF_VAL (STUFF_VAL)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc_en   (cnt_inc),
        .in_bit   (s_in),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

    // This bit completes a run, so the TX side must insert after it.
    assign run_hit = (s_in == STUFF_VAL) && (cnt == CNT_W'(RUN_LEN - 1));

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        endb_pend_d  = endb_pend_q;
        first_d      = first_q;
        s_out_d      = 1'b0;
        out_valid_d  = 1'b0;
        start_nrzi_d = 1'b0;
        done_d       = 1'b0;
        stuff_err_d  = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACTIVE;
                    mode_d      = stuff_mode_t'(mode);
                    first_d     = 1'b1;
                    endb_pend_d = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    cnt_inc = 1'b1;
                    if (mode_q == UNSTUFF_RX && at_limit) begin
                        if (s_in == STUFF_VAL) begin
                            stuff_err_d = 1'b1;
                            state_d     = IDLE;
                        end else if (endb) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        s_out_d      = s_in;
                        out_valid_d  = 1'b1;
                        start_nrzi_d = first_q;
                        first_d      = 1'b0;
                        if (mode_q == STUFF_TX && run_hit) begin
                            state_d     = INSERT;
                            endb_pend_d = endb;
                        end else if (endb) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            INSERT: begin
                s_out_d     = ~STUFF_VAL;
                out_valid_d = 1'b1;
                cnt_clr     = 1'b1;
                done_d      = endb_pend_q;
                state_d     = endb_pend_q ? IDLE : ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= STUFF_TX;
            endb_pend_q  <= 1'b0;
            first_q      <= 1'b0;
            s_out_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            start_nrzi_q <= 1'b0;
            done_q       <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            endb_pend_q  <= endb_pend_d;
            first_q      <= first_d;
            s_out_q      <= s_out_d;
            out_valid_q  <= out_valid_d;
            start_nrzi_q <= start_nrzi_d;
            done_q       <= done_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign pause      = (state_q == INSERT);
    assign busy       = (state_q != IDLE);
    assign s_out      = s_out_q;
    assign out_valid  = out_valid_q;
    assign start_nrzi = start_nrzi_q;
    assign done       = done_q;
    assign stuff_err  = stuff_err_q;

endmodule
